// File: rtl/seven_seg_scheduler.sv
// Four-source seven-segment display scheduler: source rotation, sequential
// shift-add-3 binary-to-BCD conversion, and multiplexed digit scan.
module seven_seg_scheduler #(
  parameter int DWELL    = 100000000,
  parameter int SCAN_DIV = 250000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [12:0] src0,
  input  logic [12:0] src1,
  input  logic [12:0] src2,
  input  logic [12:0] src3,
  input  logic        auto_en,
  input  logic        next_btn,
  output logic [1:0]  cur_src,
  output logic [1:0]  digit_sel,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic        busy,
  output logic        conv_done,
  output logic        ovf
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SC_W-1:0] SCAN_LAST  = SC_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, LATCH, CONV, DONE} state_t;

  // ---------------- source selection ----------------
  logic            btn_q, auto_q;
  logic            btn_edge, auto_chg, expire, step;
  logic [DW_W-1:0] dwell_cnt;

  assign btn_edge = next_btn & ~btn_q;
  assign auto_chg = auto_en ^ auto_q;
  assign expire   = auto_en & ~auto_chg & (dwell_cnt == DWELL_LAST);
  // A coincident button edge and dwell expiry collapse into one step
  assign step     = btn_edge | expire;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      btn_q     <= 1'b0;
      auto_q    <= 1'b0;
      dwell_cnt <= '0;
      cur_src   <= 2'd0;
    end else begin
      btn_q  <= next_btn;
      auto_q <= auto_en;
      if (step)
        cur_src <= cur_src + 2'd1;
      if (auto_chg || !auto_en || step)
        dwell_cnt <= '0;
      else
        dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  logic [12:0] src_sel;

  always_comb begin
    case (cur_src)
      2'd0:    src_sel = src0;
      2'd1:    src_sel = src1;
      2'd2:    src_sel = src2;
      default: src_sel = src3;
    endcase
  end

  // ---------------- converter ----------------
  state_t          state;
  logic [11:0]     bin;
  logic            sign, big;
  logic [15:0]     bcd, adj;
  logic [3:0]      iter;
  logic [3:0][3:0] disp;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bin       <= '0;
      sign      <= 1'b0;
      big       <= 1'b0;
      bcd       <= '0;
      iter      <= '0;
      disp      <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        IDLE: begin
          state <= LATCH;
          busy  <= 1'b1;
        end
        LATCH: begin
          bin   <= src_sel[11:0];
          sign  <= src_sel[12];
          // magnitude is shifted out during CONV, so keep its range flag now
          big   <= src_sel[11:0] > 12'd999;
          bcd   <= '0;
          iter  <= '0;
          state <= CONV;
          busy  <= 1'b1;
        end
        CONV: begin
          {bcd, bin} <= {adj, bin} << 1;
          iter       <= iter + 4'd1;
          if (iter == 4'd11) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          disp[0]   <= bcd[3:0];
          disp[1]   <= bcd[7:4];
          disp[2]   <= bcd[11:8];
          disp[3]   <= sign ? 4'd10 : bcd[15:12];
          ovf       <= sign & big;
          conv_done <= 1'b1;
          busy      <= 1'b1;
          state     <= LATCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- digit scan ----------------
  logic [SC_W-1:0] scan_cnt;
  logic            scan_wrap;
  logic [1:0]      sel_nxt;

  assign scan_wrap = (scan_cnt == SCAN_LAST);
  assign sel_nxt   = scan_wrap ? digit_sel + 2'd1 : digit_sel;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_sel <= 2'd0;
      anode     <= 4'b1110;
      digit     <= 4'd0;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      digit_sel <= sel_nxt;
      digit     <= disp[sel_nxt];
      anode     <= ~(4'b0001 << sel_nxt);
    end
  end

endmodule

// File: tb/tb_seven_seg_scheduler.sv
// Directed bench for seven_seg_scheduler: conversion table plus timing,
// rotation, mid-conversion source change and mid-conversion reset sequences.
module tb_seven_seg_scheduler;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [12:0] src0, src1, src2, src3;
  logic        auto_en, next_btn;
  logic [1:0]  cur_src, digit_sel;
  logic [3:0]  anode, digit;
  logic        busy, conv_done, ovf;

  int checks   = 0;
  int failures = 0;

  seven_seg_scheduler #(.DWELL(20), .SCAN_DIV(4)) dut (
    .clk_in(clk_in), .rst(rst),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .auto_en(auto_en), .next_btn(next_btn),
    .cur_src(cur_src), .digit_sel(digit_sel), .anode(anode), .digit(digit),
    .busy(busy), .conv_done(conv_done), .ovf(ovf)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [12:0] val;
    logic [15:0] exp;   // nibble i = expected digit at digit_sel i
    logic        eovf;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic wait_conv();
    int n = 0;
    while (conv_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("conv_done_timeout", {31'd0, conv_done}, 32'd1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_cur_src"}, cur_src, 0);
    chk({nm, "_digit_sel"}, digit_sel, 0);
    chk({nm, "_anode"}, anode, 4'b1110);
    chk({nm, "_digit"}, digit, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_conv_done"}, conv_done, 0);
    chk({nm, "_ovf"}, ovf, 0);
  endtask

  // Edges counted from reset release: busy high except on edge 14, done on 15
  task automatic post_reset_timing(input string nm);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk({nm, "_busy"}, busy, (k == 14) ? 0 : 1);
      chk({nm, "_conv_done"}, conv_done, (k == 15) ? 1 : 0);
    end
  endtask

  task automatic check_cur_digit(input string nm, input logic [15:0] exp);
    logic [3:0] e;
    e = exp[{digit_sel, 2'b00} +: 4];
    chk(nm, digit, e);
  endtask

  task automatic check_vec(input logic [15:0] exp, input logic eovf, input string nm);
    logic [3:0] ea;
    wait_conv(); tick();
    wait_conv(); tick();
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (digit_sel != i[1:0] && n < 20) begin
        tick();
        n++;
      end
      ea = 4'b1111;
      ea[i] = 1'b0;
      chk({nm, "_sel"}, digit_sel, i);
      chk({nm, "_digit"}, digit, exp[4*i +: 4]);
      chk({nm, "_anode"}, anode, ea);
    end
    chk({nm, "_ovf"}, ovf, eovf);
  endtask

  initial begin
    vecs[0] = '{13'h04D2, 16'h1234, 1'b0, "pos1234"};
    vecs[1] = '{13'h107B, 16'hA123, 1'b0, "neg123"};
    vecs[2] = '{13'h1FFF, 16'hA095, 1'b1, "neg4095"};
    vecs[3] = '{13'h0FFF, 16'h4095, 1'b0, "pos4095"};
    vecs[4] = '{13'h0000, 16'h0000, 1'b0, "zero"};
    vecs[5] = '{13'h1000, 16'hA000, 1'b0, "negzero"};
    vecs[6] = '{13'h13E7, 16'hA999, 1'b0, "neg999"};
    vecs[7] = '{13'h13E8, 16'hA000, 1'b1, "neg1000"};
    vecs[8] = '{13'h0F10, 16'h3856, 1'b0, "pos3856"};
    vecs[9] = '{13'h03E7, 16'h0999, 1'b0, "pos999"};

    rst = 1'b1; auto_en = 1'b0; next_btn = 1'b0;
    src0 = 13'h04D2; src1 = 13'h14D2; src2 = 13'h0FFF; src3 = 13'h0F10;
    repeat (3) @(negedge clk_in);
    check_reset_vals("reset");
    rst = 1'b0;
    post_reset_timing("first_conv");

    foreach (vecs[v]) begin
      src0 = vecs[v].val;
      check_vec(vecs[v].exp, vecs[v].eovf, vecs[v].name);
    end
    src0 = 13'h04D2;

    // auto rotation: first step 21 edges after enabling, then every 20
    auto_en = 1'b1;
    repeat (20) tick();
    chk("auto_hold0", cur_src, 0);
    tick();
    chk("auto_step1", cur_src, 1);
    for (int s = 2; s <= 4; s++) begin
      repeat (19) tick();
      chk("auto_hold", cur_src, (s - 1) % 4);
      tick();
      chk("auto_step", cur_src, s % 4);
    end
    repeat (19) tick();
    next_btn = 1'b1;
    tick();
    chk("btn_on_expiry", cur_src, 1);
    repeat (19) tick();
    chk("after_coincide_hold", cur_src, 1);
    tick();
    chk("after_coincide_step", cur_src, 2);

    auto_en = 1'b0; next_btn = 1'b0;
    tick();
    next_btn = 1'b1;
    tick();
    chk("manual_step", cur_src, 3);
    repeat (9) tick();
    chk("manual_held", cur_src, 3);
    repeat (25) tick();
    chk("manual_no_auto", cur_src, 3);
    next_btn = 1'b0;
    tick();
    chk("manual_release", cur_src, 3);

    // source change mid-CONV: next result is still src3, the one after is src0
    wait_conv();
    repeat (3) tick();
    chk("midconv_busy", busy, 1);
    next_btn = 1'b1;
    tick();
    next_btn = 1'b0;
    chk("midconv_step", cur_src, 0);
    wait_conv(); tick();
    check_cur_digit("midconv_old_src", 16'h3856);
    wait_conv(); tick();
    check_cur_digit("midconv_new_src", 16'h1234);

    // reset mid-CONV with nonzero state everywhere
    next_btn = 1'b1;
    tick();
    next_btn = 1'b0;
    wait_conv(); tick();
    wait_conv(); tick();
    wait_conv();
    repeat (5) tick();
    chk("pre_rst_cur_src", cur_src, 1);
    chk("pre_rst_ovf", ovf, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk_in);
    check_reset_vals("mid_rst_held");
    rst = 1'b0;
    post_reset_timing("rst_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
